// File: rtl/sb_bus_pkg.sv
// Shared types and constants for the system-bus controller.
//   state_t       : controller FSM states
//   ERR_TO_BIT    : status bit for the ack-timeout flag
//   ERR_MULTI_BIT : status bit for the multi-ack flag
//   *_DEF         : default timeout read data and status register address
package sb_bus_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ERR_TO_BIT    = 7;
  localparam int unsigned ERR_MULTI_BIT = 6;

  localparam logic [DATA_W-1:0] ERR_BYTE_DEF  = 8'hFF;
  localparam logic [DATA_W-1:0] STAT_ADDR_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCAL  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sb_ack_mux.sv
// Per-slave gated read-data merge with ack presence and multi-ack detection.
//   sb_dat_i    : slave read data, slave k at [8k+7:8k]
//   sb_ack_i    : slave acks
//   data_c      : OR of each slave's data gated by its own ack
//   any_ack_c   : at least one ack high
//   multi_ack_c : two or more acks high
module sb_ack_mux
  import sb_bus_pkg::*;
#(
  parameter int unsigned NUM_SLV = 3
) (
  input  logic [DATA_W*NUM_SLV-1:0] sb_dat_i,
  input  logic [NUM_SLV-1:0]        sb_ack_i,
  output logic [DATA_W-1:0]         data_c,
  output logic                      any_ack_c,
  output logic                      multi_ack_c
);

  // Unacked slaves contribute nothing, so idle slaves driving 1s cannot corrupt data.
  always_comb begin
    data_c      = '0;
    any_ack_c   = 1'b0;
    multi_ack_c = 1'b0;
    for (int k = 0; k < int'(NUM_SLV); k++) begin
      if (sb_ack_i[k]) begin
        multi_ack_c = multi_ack_c | any_ack_c;
        any_ack_c   = 1'b1;
      end
      data_c = data_c | (sb_dat_i[DATA_W*k +: DATA_W] & {DATA_W{sb_ack_i[k]}});
    end
  end

endmodule

// File: rtl/sb_bus_ctrl.sv
// CPU register port to iCE40 hard-IP system-bus master with ack watchdog,
// multi-ack detection and a local status/control register.
//   clk, rst_n          : clock, async active-low reset
//   cs, we, addr, din   : CPU request, sampled on the cs rising edge
//   dout, rdy           : read data (held) and one-cycle completion pulse
//   sb_stb, sb_rw,
//   sb_adr, sb_dat_o    : system-bus request
//   sb_dat_i, sb_ack_i  : per-slave read data and acks
//   irq                 : high while a sticky error flag is set
module sb_bus_ctrl
  import sb_bus_pkg::*;
#(
  parameter int unsigned         NUM_SLV   = 3,
  parameter int unsigned         TO_CYCLES = 64,
  parameter logic [DATA_W-1:0]   ERR_BYTE  = ERR_BYTE_DEF,
  parameter logic [DATA_W-1:0]   STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      we,
  input  logic [DATA_W-1:0]         addr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      rdy,
  output logic                      sb_stb,
  output logic                      sb_rw,
  output logic [DATA_W-1:0]         sb_adr,
  output logic [DATA_W-1:0]         sb_dat_o,
  input  logic [DATA_W*NUM_SLV-1:0] sb_dat_i,
  input  logic [NUM_SLV-1:0]        sb_ack_i,
  output logic                      irq
);

  localparam int unsigned CNT_W = $clog2(TO_CYCLES + 1);

  state_t              state, state_d;
  logic                cs_d;
  logic [CNT_W-1:0]    to_cnt, to_cnt_d;
  logic                err_to, err_to_d;
  logic                err_multi, err_multi_d;
  logic                loc_we, loc_we_d;
  logic                loc_clr_to, loc_clr_to_d;
  logic                loc_clr_multi, loc_clr_multi_d;
  logic [DATA_W-1:0]   dout_d;
  logic                rdy_d;
  logic                sb_stb_d;
  logic                sb_rw_d;
  logic [DATA_W-1:0]   sb_adr_d;
  logic [DATA_W-1:0]   sb_dat_o_d;
  logic                irq_d;

  logic                start_c;
  logic [DATA_W-1:0]   ack_data_c;
  logic                any_ack_c;
  logic                multi_ack_c;
  logic [DATA_W-1:0]   stat_c;

  sb_ack_mux #(
    .NUM_SLV (NUM_SLV)
  ) u_ack_mux (
    .sb_dat_i    (sb_dat_i),
    .sb_ack_i    (sb_ack_i),
    .data_c      (ack_data_c),
    .any_ack_c   (any_ack_c),
    .multi_ack_c (multi_ack_c)
  );

  assign start_c = cs & ~cs_d;

  // Status register image: sticky flags on top, slave count minus one at the bottom.
  always_comb begin
    stat_c                = '0;
    stat_c[ERR_TO_BIT]    = err_to;
    stat_c[ERR_MULTI_BIT] = err_multi;
    stat_c[2:0]           = 3'(NUM_SLV - 1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cs_d          <= 1'b0;
      to_cnt        <= '0;
      err_to        <= 1'b0;
      err_multi     <= 1'b0;
      loc_we        <= 1'b0;
      loc_clr_to    <= 1'b0;
      loc_clr_multi <= 1'b0;
      dout          <= '0;
      rdy           <= 1'b0;
      sb_stb        <= 1'b0;
      sb_rw         <= 1'b0;
      sb_adr        <= '0;
      sb_dat_o      <= '0;
      irq           <= 1'b0;
    end else begin
      state         <= state_d;
      cs_d          <= cs;
      to_cnt        <= to_cnt_d;
      err_to        <= err_to_d;
      err_multi     <= err_multi_d;
      loc_we        <= loc_we_d;
      loc_clr_to    <= loc_clr_to_d;
      loc_clr_multi <= loc_clr_multi_d;
      dout          <= dout_d;
      rdy           <= rdy_d;
      sb_stb        <= sb_stb_d;
      sb_rw         <= sb_rw_d;
      sb_adr        <= sb_adr_d;
      sb_dat_o      <= sb_dat_o_d;
      irq           <= irq_d;
    end
  end

  // Next-state and next-output logic; rdy and dout are set on entry to DONE
  // so they are visible during the DONE cycle itself.
  always_comb begin
    state_d         = state;
    to_cnt_d        = to_cnt;
    err_to_d        = err_to;
    err_multi_d     = err_multi;
    loc_we_d        = loc_we;
    loc_clr_to_d    = loc_clr_to;
    loc_clr_multi_d = loc_clr_multi;
    dout_d          = dout;
    rdy_d           = 1'b0;
    sb_stb_d        = sb_stb;
    sb_rw_d         = sb_rw;
    sb_adr_d        = sb_adr;
    sb_dat_o_d      = sb_dat_o;

    unique case (state)
      IDLE: begin
        if (start_c) begin
          if (addr == STAT_ADDR) begin
            state_d         = LOCAL;
            loc_we_d        = we;
            loc_clr_to_d    = din[ERR_TO_BIT];
            loc_clr_multi_d = din[ERR_MULTI_BIT];
          end else begin
            state_d    = STROBE;
            sb_adr_d   = addr;
            sb_dat_o_d = din;
            sb_rw_d    = we;
            sb_stb_d   = 1'b1;
            to_cnt_d   = '0;
          end
        end
      end

      STROBE: begin
        // An ack in the final watchdog cycle still completes normally.
        if (any_ack_c) begin
          state_d  = DONE;
          sb_stb_d = 1'b0;
          to_cnt_d = '0;
          rdy_d    = 1'b1;
          if (!sb_rw) dout_d = ack_data_c;
          if (multi_ack_c) err_multi_d = 1'b1;
        end else if (to_cnt == CNT_W'(TO_CYCLES - 1)) begin
          state_d  = DONE;
          sb_stb_d = 1'b0;
          to_cnt_d = '0;
          rdy_d    = 1'b1;
          if (!sb_rw) dout_d = ERR_BYTE;
          err_to_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt + CNT_W'(1);
        end
      end

      LOCAL: begin
        state_d = DONE;
        rdy_d   = 1'b1;
        if (loc_we) begin
          if (loc_clr_to)    err_to_d    = 1'b0;
          if (loc_clr_multi) err_multi_d = 1'b0;
        end else begin
          dout_d = stat_c;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    irq_d = err_to_d | err_multi_d;
  end

endmodule

// File: tb/tb_sb_bus_ctrl.sv
// Scoreboard bench for sb_bus_ctrl: expected completions are queued at issue
// time and checked by an independent monitor on every rdy pulse.
module tb_sb_bus_ctrl;

  localparam int unsigned NS = 3;
  localparam int unsigned TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cs, we;
  logic [7:0]      addr, din, dout;
  logic            rdy, sb_stb, sb_rw, irq;
  logic [7:0]      sb_adr, sb_dat_o;
  logic [8*NS-1:0] sb_dat_i;
  logic [NS-1:0]   sb_ack_i;

  typedef struct {
    logic [7:0] dout;
    logic       irq;
    int         stb_len;   // -1 = not checked
    logic       chk_bus;
    logic [7:0] adr;
    logic       rw;
    logic [7:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // slave model configuration (written only by the stimulus process)
  logic          ack_en = 1'b0;
  logic [NS-1:0] ack_mask = '0;
  int            ack_delay = 0;
  logic [NS-1:0] stray_ack = '0;

  // bus observation (written only by the slave process)
  int         stb_total = 0;
  logic [7:0] seen_adr = '0, seen_dat = '0;
  logic       seen_rw = 1'b0;

  sb_bus_ctrl #(
    .NUM_SLV   (NS),
    .TO_CYCLES (TO),
    .ERR_BYTE  (8'hFF),
    .STAT_ADDR (8'hFF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .rdy      (rdy),
    .sb_stb   (sb_stb),
    .sb_rw    (sb_rw),
    .sb_adr   (sb_adr),
    .sb_dat_o (sb_dat_o),
    .sb_dat_i (sb_dat_i),
    .sb_ack_i (sb_ack_i),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic i, input int len,
                              input logic cb, input logic [7:0] a, input logic r,
                              input logic [7:0] w);
    exp_t e;
    e.dout = d; e.irq = i; e.stb_len = len;
    e.chk_bus = cb; e.adr = a; e.rw = r; e.dat = w;
    return e;
  endfunction

  // Slave model: acks ack_delay cycles after the strobe first appears.
  initial begin
    int stb_cnt;
    stb_cnt  = 0;
    sb_ack_i = '0;
    forever begin
      @(negedge clk);
      if (sb_stb) begin
        stb_total++;
        seen_adr = sb_adr;
        seen_rw  = sb_rw;
        seen_dat = sb_dat_o;
        sb_ack_i = (ack_en && stb_cnt == ack_delay) ? ack_mask : '0;
        stb_cnt++;
      end else begin
        sb_ack_i = stray_ack;
        stb_cnt  = 0;
      end
    end
  end

  // Scoreboard monitor: every rdy pulse must match the oldest queued expectation.
  initial begin
    int   last_total;
    exp_t e;
    last_total = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rdy === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdy_unexpected actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("dout", 32'(dout), 32'(e.dout));
          chk("irq", 32'(irq), 32'(e.irq));
          if (e.stb_len >= 0) chk("stb_len", 32'(stb_total - last_total), 32'(e.stb_len));
          if (e.chk_bus) begin
            chk("sb_adr", 32'(seen_adr), 32'(e.adr));
            chk("sb_rw", 32'(seen_rw), 32'(e.rw));
            chk("sb_dat_o", 32'(seen_dat), 32'(e.dat));
          end
        end
        last_total = stb_total;
      end
    end
  end

  task automatic slave(input logic en, input logic [NS-1:0] mask, input int dly,
                       input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    ack_en    = en;
    ack_mask  = mask;
    ack_delay = dly;
    sb_dat_i  = {d2, d1, d0};
  endtask

  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                     input int hold, input int gap, input exp_t e);
    sb_q.push_back(e);
    @(negedge clk);
    cs = 1'b1; we = w; addr = a; din = d;
    repeat (hold) @(negedge clk);
    cs = 1'b0;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout actual=pending expected=done addr=%0h", a);
      sb_q.delete();
    end
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    sb_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_stb", 32'(sb_stb), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_bus", {23'h0, sb_rw, sb_adr}, 32'h0);
    chk("rst_dat_o", 32'(sb_dat_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // status read with clean flags: {0,0,000,NUM_SLV-1}
    txn(1'b0, 8'hFF, 8'h00, 1, 2, mk(8'h02, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00));

    // read, slave 1 acks 3 cycles after strobe; others drive FF unacked
    slave(1'b1, 3'b010, 3, 8'hFF, 8'h5A, 8'hFF);
    txn(1'b0, 8'h10, 8'h00, 1, 2, mk(8'h5A, 1'b0, 4, 1'b1, 8'h10, 1'b0, 8'h00));

    // write, slave 0 acks immediately; dout must hold
    slave(1'b1, 3'b001, 0, 8'hFF, 8'hFF, 8'hCC);
    txn(1'b1, 8'h08, 8'h3C, 1, 2, mk(8'h5A, 1'b0, 1, 1'b1, 8'h08, 1'b1, 8'h3C));

    // read with no ack: watchdog aborts after TO strobe cycles
    slave(1'b0, 3'b000, 0, 8'hFF, 8'hFF, 8'hFF);
    txn(1'b0, 8'h20, 8'h00, 1, 2, mk(8'hFF, 1'b1, 8, 1'b1, 8'h20, 1'b0, 8'h00));
    txn(1'b0, 8'hFF, 8'h00, 1, 2, mk(8'h82, 1'b1, 0, 1'b0, 8'h00, 1'b0, 8'h00));
    txn(1'b1, 8'hFF, 8'h80, 1, 2, mk(8'h82, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00));

    // slaves 0 and 2 ack together
    slave(1'b1, 3'b101, 1, 8'h10, 8'hFF, 8'h01);
    txn(1'b0, 8'h24, 8'h00, 1, 2, mk(8'h11, 1'b1, 2, 1'b1, 8'h24, 1'b0, 8'h00));
    txn(1'b0, 8'hFF, 8'h00, 1, 2, mk(8'h42, 1'b1, 0, 1'b0, 8'h00, 1'b0, 8'h00));
    txn(1'b1, 8'hFF, 8'h40, 1, 2, mk(8'h42, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00));
    txn(1'b0, 8'hFF, 8'h00, 1, 2, mk(8'h02, 1'b0, 0, 1'b0, 8'h00, 1'b0, 8'h00));

    // cs held high 20 cycles: one transaction only, then a new edge after one low cycle
    slave(1'b1, 3'b100, 0, 8'h77, 8'hFF, 8'hFF);
    txn(1'b0, 8'h30, 8'h00, 20, 0, mk(8'h77, 1'b0, 1, 1'b1, 8'h30, 1'b0, 8'h00));
    slave(1'b1, 3'b001, 2, 8'hFF, 8'hFF, 8'h3E);
    txn(1'b0, 8'h31, 8'h00, 1, 2, mk(8'h3E, 1'b0, 3, 1'b1, 8'h31, 1'b0, 8'h00));

    // reset in the middle of a strobe: aborts with no rdy
    slave(1'b0, 3'b000, 0, 8'hFF, 8'hFF, 8'hFF);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 8'h50; din = 8'h00;
    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("stb_before_rst", 32'(sb_stb), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("stb_async_rst", 32'(sb_stb), 32'h0);
    chk("rdy_async_rst", 32'(rdy), 32'h0);
    repeat (2) @(negedge clk);
    chk("dout_after_rst", 32'(dout), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // stray acks while idle set no flag
    stray_ack = 3'b111;
    repeat (3) @(negedge clk);
    stray_ack = '0;
    @(negedge clk);
    chk("irq_stray_ack", 32'(irq), 32'h0);
    txn(1'b0, 8'hFF, 8'h00, 1, 2, mk(8'h02, 1'b0, -1, 1'b0, 8'h00, 1'b0, 8'h00));

    // normal transaction after the aborted one
    slave(1'b1, 3'b010, 1, 8'hFF, 8'hA5, 8'hFF);
    txn(1'b0, 8'h40, 8'h00, 1, 4, mk(8'hA5, 1'b0, 2, 1'b1, 8'h40, 1'b0, 8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_bus_ctrl.md
Name: sb_bus_ctrl

Overview:
Parametrised byte-wide controller that bridges the CPU register port to the iCE40 hard-IP system bus (SB_SPI / SB_I2C style slaves). It supports NUM_SLV slaves, with per-slave ack/data gating instead of a blind OR. It adds an ack-timeout watchdog, multi-ack detection and a local status/control register. It replaces the fixed three-slave master inside the peripheral bus wrapper and sits between the CPU bus decoder and the hard IP instances.

Parameters:
NUM_SLV, 3, number of system-bus slaves attached (1..8)
TO_CYCLES, 64, clk cycles a strobe may stay unacknowledged before abort (4..1023)
ERR_BYTE, 8'hFF, read data returned on timeout
STAT_ADDR, 8'hFF, local status register address (never forwarded to the bus)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active-low
cs  in  1  CPU chip select; a rising edge starts a transaction
we  in  1  1 = write, 0 = read; sampled on the cs rising edge
addr  in  8  register address; sampled on the cs rising edge
din  in  8  write data; sampled on the cs rising edge
dout  out  8  read data; held until the next completed transaction
rdy  out  1  one-cycle completion pulse
sb_stb  out  1  system-bus strobe
sb_rw  out  1  system-bus direction (1 = write)
sb_adr  out  8  system-bus address
sb_dat_o  out  8  system-bus write data
sb_dat_i  in  8*NUM_SLV  slave read data, slave k at bits [8k+7:8k]
sb_ack_i  in  NUM_SLV  slave acks
irq  out  1  high while err_to or err_multi is set

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; dout = 0, rdy = 0, sb_stb = 0, sb_rw = 0, sb_adr = 0, sb_dat_o = 0, irq = 0.
  - Sticky flags, to_cnt and the cs edge register are cleared.
  - Reset mid-transaction aborts the transaction; no rdy is issued.
- cs is registered (cs_d). Start condition: cs & ~cs_d, accepted only in IDLE. Edges arriving in any other state are ignored.
- States: IDLE, LOCAL, STROBE, DONE.
- IDLE -> LOCAL when start and addr == STAT_ADDR. Otherwise IDLE -> STROBE; addr, din and we are latched into sb_adr, sb_dat_o and sb_rw, and sb_stb = 1 from the next cycle.
- STROBE:
  - sb_stb held at 1; to_cnt increments each cycle.
  - Any bit of sb_ack_i high -> DONE. The captured read data is the OR over k of (sb_dat_i slice k AND {8{sb_ack_i[k]}}).
  - More than one ack bit high in that cycle -> err_multi = 1. The data is still the gated OR.
  - to_cnt == TO_CYCLES-1 with no ack -> DONE; captured data = ERR_BYTE; err_to = 1.
  - Ack and timeout in the same cycle: the ack wins and err_to is not set.
  - On exit sb_stb = 0 and to_cnt = 0.
- LOCAL:
  - Read: captured data = {err_to, err_multi, 3'b0, NUM_SLV-1 (3 bits)}.
  - Write: din[7] = 1 clears err_to; din[6] = 1 clears err_multi.
  - Next state DONE. A local write in the same cycle as flag setting is impossible (the FSM is single-threaded).
- DONE:
  - rdy = 1 for exactly one cycle. dout is updated with the captured data on reads only; writes leave dout unchanged.
  - Next state IDLE.
- Latency, with the cs edge sampled at cycle N:
  - sb_stb high from N+1.
  - An ack in cycle N+1+m gives rdy and valid dout at N+2+m.
  - A local access gives rdy at N+2.
- Ack ignored outside STROBE. A stray ack in IDLE sets no flag.
- cs held high across rdy does not retrigger; cs must go low for at least one cycle first.
- irq = err_to | err_multi, registered.

Decomposition:
- Package sb_bus_pkg holds:
  - state enum {IDLE, LOCAL, STROBE, DONE}
  - STAT bit indices (ERR_TO = 7, ERR_MULTI = 6)
  - default ERR_BYTE and STAT_ADDR constants
- One sub-module, sb_ack_mux: parametrised gated-OR of data, any_ack, and a multi_ack detector (combinational, NUM_SLV wide).

Test Plan:
- Read, slave 1 acks 3 cycles after sb_stb with 8'h5A, other slaves drive 8'hFF unacked -> dout = 8'h5A, rdy one cycle, no flags.
- Write addr 8'h08, din 8'h3C, slave 0 acks -> sb_adr = 8'h08, sb_dat_o = 8'h3C, sb_rw = 1 during strobe; dout unchanged; rdy once.
- Read with no ack, TO_CYCLES = 8 -> sb_stb high exactly 8 cycles; dout = 8'hFF; irq = 1; status read returns 8'h82 (NUM_SLV = 3).
- Slaves 0 and 2 ack together with 8'h01 and 8'h10 -> dout = 8'h11, err_multi = 1; write 8'h40 to STAT_ADDR -> status bit 6 clears and irq drops.
- cs held high for 20 cycles -> exactly one transaction and one rdy; a new cs edge after one low cycle starts a second.
- rst_n asserted while in STROBE -> sb_stb = 0 asynchronously, no rdy, next transaction completes normally.
